pellet_tracker: RTL and testbench

- Sits directly downstream of pacman_controller and consumes its tile position outputs curr_x/curr_y.
- Holds a 32x32 pellet bitmap and detects when Pac-Man enters a tile that still has a pellet.
- On each such entry it clears the pellet, adds points to the score, decrements the remaining-pellet count, and flags level clear when the count reaches 0.

---
 rtl/pacman_pkg.sv | 31 +++
 rtl/popcount32.sv | 14 +
 rtl/pellet_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_pellet_tracker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man constants: grid geometry, default maze/power bitmaps, tracker FSM states.
// Map bit index = y*GRID + x; 1 = pellet (or power tile) present.
package pacman_pkg;

  localparam int unsigned COORD_W  = 5;
  localparam int unsigned GRID     = 32;
  localparam int unsigned MAP_BITS = GRID * GRID;

  localparam int unsigned PELLET_POINTS_DEF = 10;
  localparam int unsigned POWER_POINTS_DEF  = 50;

  // Outer ring of rows 0/31 and columns 0/31 is wall; everything else holds a pellet.
  localparam logic [MAP_BITS-1:0] MAZE_PELLETS = {32'h0000_0000, {30{32'h7FFF_FFFE}}, 32'h0000_0000};

  // Power tiles in the four inner corners: (1,1), (30,1), (1,30), (30,30).
  localparam logic [MAP_BITS-1:0] POWER_MAP = (1024'd1 << 33)  | (1024'd1 << 62) |
                                              (1024'd1 << 961) | (1024'd1 << 990);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [GRID-1:0] map_row(input logic [MAP_BITS-1:0] map,
                                               input logic [COORD_W-1:0] row);
    return map[{row, 5'd0} +: GRID];
  endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word.
module popcount32 (
  input  logic [31:0] row_i,
  output logic [5:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      count_o = count_o + 6'(row_i[i]);
    end
  end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet bitmap tracker: clears pellets as Pac-Man enters tiles, keeps score and pellet count.
// Optional power pellets enabled by defining PELLET_TRACKER_POWER_EN.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned          SCORE_W       = 16,
  parameter int unsigned          PELLET_POINTS = PELLET_POINTS_DEF,
  parameter int unsigned          POWER_POINTS  = POWER_POINTS_DEF,
  parameter logic [MAP_BITS-1:0]  PELLET_MAP    = MAZE_PELLETS
`ifdef PELLET_TRACKER_POWER_EN
  , parameter logic [MAP_BITS-1:0] POWER_TILE_MAP = pacman_pkg::POWER_MAP
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [COORD_W-1:0] curr_x,
  input  logic [COORD_W-1:0] curr_y,
  output logic               eat,
  output logic               power_up,
  output logic [SCORE_W-1:0] score,
  output logic [10:0]        pellets_left,
  output logic               level_clear,
  output logic               busy
);

  localparam int unsigned SUM_W = SCORE_W + 1;

  state_e                 state_q, state_d;
  logic [COORD_W-1:0]     row_cnt_q, row_cnt_d;
  logic                   pos_valid_q, pos_valid_d;
  logic [2*COORD_W-1:0]   last_pos_q, last_pos_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [10:0]            pellets_q, pellets_d;
  logic                   eat_q, eat_d;
  logic                   power_d;

  logic [GRID-1:0]        map_ram [GRID];
  logic                   ram_we;
  logic [COORD_W-1:0]     ram_waddr;
  logic [GRID-1:0]        ram_wdata;

  logic [GRID-1:0]        init_row;
  logic [5:0]             init_pop;
  logic [10:0]            init_total;
  logic [COORD_W-1:0]     last_x, last_y;
  logic [GRID-1:0]        chk_row;
  logic                   hit;
  logic                   is_power;
  logic                   pos_changed;
  logic [SUM_W-1:0]       pts;
  logic [SUM_W-1:0]       score_sum;
  logic [SCORE_W-1:0]     score_sat;

  popcount32 u_popcount (
    .row_i   (init_row),
    .count_o (init_pop)
  );

  assign init_row    = map_row(PELLET_MAP, row_cnt_q);
  assign init_total  = pellets_q + 11'(init_pop);
  assign last_x      = last_pos_q[COORD_W-1:0];
  assign last_y      = last_pos_q[2*COORD_W-1:COORD_W];
  assign chk_row     = map_ram[last_y];
  assign hit         = chk_row[last_x];
  assign pos_changed = !pos_valid_q || ({curr_y, curr_x} != last_pos_q);

`ifdef PELLET_TRACKER_POWER_EN
  logic power_q;
  assign is_power = POWER_TILE_MAP[last_pos_q];
`else
  assign is_power = 1'b0;
`endif

  assign pts       = is_power ? SUM_W'(POWER_POINTS) : SUM_W'(PELLET_POINTS);
  assign score_sum = {1'b0, score_q} + pts;
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; restart overrides everything, including a CHECK in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: begin
        if (row_cnt_q == COORD_W'(GRID - 1)) begin
          state_d = (init_total == '0) ? DONE : IDLE;
        end
      end
      IDLE: begin
        if (pos_changed) state_d = CHECK;
      end
      CHECK: begin
        state_d = (hit && pellets_q == 11'd1) ? DONE : IDLE;
      end
      DONE: state_d = DONE;
    endcase
    if (restart) state_d = INIT;
  end

  // Output logic
  always_comb begin
    busy         = (state_q == INIT);
    level_clear  = (state_q == DONE);
    eat          = eat_q;
    score        = score_q;
    pellets_left = pellets_q;
`ifdef PELLET_TRACKER_POWER_EN
    power_up     = power_q;
`else
    power_up     = 1'b0;
`endif
  end

  // Datapath next-state and map write port
  always_comb begin
    row_cnt_d   = row_cnt_q;
    pos_valid_d = pos_valid_q;
    last_pos_d  = last_pos_q;
    score_d     = score_q;
    pellets_d   = pellets_q;
    eat_d       = 1'b0;
    power_d     = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = row_cnt_q;
    ram_wdata   = init_row;
    unique case (state_q)
      INIT: begin
        ram_we      = 1'b1;
        row_cnt_d   = row_cnt_q + 1'b1;
        pellets_d   = init_total;
        pos_valid_d = 1'b0;
      end
      IDLE: begin
        if (pos_changed) begin
          last_pos_d  = {curr_y, curr_x};
          pos_valid_d = 1'b1;
        end
      end
      CHECK: begin
        if (hit) begin
          ram_we    = 1'b1;
          ram_waddr = last_y;
          ram_wdata = chk_row & ~(GRID'(1) << last_x);
          score_d   = score_sat;
          pellets_d = pellets_q - 1'b1;
          eat_d     = 1'b1;
          power_d   = is_power;
        end
      end
      DONE: ;
    endcase
    if (restart) begin
      row_cnt_d   = '0;
      pos_valid_d = 1'b0;
      score_d     = score_q;
      pellets_d   = '0;
      eat_d       = 1'b0;
      power_d     = 1'b0;
      ram_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt_q   <= '0;
      pos_valid_q <= 1'b0;
      last_pos_q  <= '0;
      score_q     <= '0;
      pellets_q   <= '0;
      eat_q       <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      pos_valid_q <= pos_valid_d;
      last_pos_q  <= last_pos_d;
      score_q     <= score_d;
      pellets_q   <= pellets_d;
      eat_q       <= eat_d;
    end
  end

`ifdef PELLET_TRACKER_POWER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) power_q <= 1'b0;
    else        power_q <= power_d;
  end
`else
  logic unused_power;
  assign unused_power = power_d;
`endif

  // Map storage is not reset; INIT always reloads every row before use.
  always_ff @(posedge clk) begin
    if (ram_we) map_ram[ram_waddr] <= ram_wdata;
  end

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: main instance with a 3-pellet map and a 6-bit-score instance.
module tb_pellet_tracker;

  localparam logic [1023:0] MAP_A = (1024'd1 << 1) | (1024'd1 << 2) | (1024'd1 << 163);
  localparam logic [1023:0] MAP_B = 1024'hFF;
`ifdef PELLET_TRACKER_POWER_EN
  localparam logic [1023:0] PMAP_A = (1024'd1 << 2);
  localparam logic [1023:0] PMAP_B = '0;
  localparam int unsigned P2     = 50;
  localparam int unsigned PWR_EN = 1;
`else
  localparam int unsigned P2     = 10;
  localparam int unsigned PWR_EN = 0;
`endif

  logic        clk, rst_n;
  logic        a_restart, b_restart;
  logic [4:0]  a_x, a_y, b_x, b_y;
  logic        a_eat, a_pwr, a_lc, a_busy;
  logic        b_eat, b_pwr, b_lc, b_busy;
  logic [15:0] a_score;
  logic [5:0]  b_score;
  logic [10:0] a_pl, b_pl;

  int checks   = 0;
  int failures = 0;

  pellet_tracker #(
    .SCORE_W(16), .PELLET_POINTS(10), .POWER_POINTS(50), .PELLET_MAP(MAP_A)
`ifdef PELLET_TRACKER_POWER_EN
    , .POWER_TILE_MAP(PMAP_A)
`endif
  ) dut_a (
    .clk(clk), .reset(rst_n), .restart(a_restart), .curr_x(a_x), .curr_y(a_y),
    .eat(a_eat), .power_up(a_pwr), .score(a_score), .pellets_left(a_pl),
    .level_clear(a_lc), .busy(a_busy)
  );

  pellet_tracker #(
    .SCORE_W(6), .PELLET_POINTS(10), .POWER_POINTS(50), .PELLET_MAP(MAP_B)
`ifdef PELLET_TRACKER_POWER_EN
    , .POWER_TILE_MAP(PMAP_B)
`endif
  ) dut_b (
    .clk(clk), .reset(rst_n), .restart(b_restart), .curr_x(b_x), .curr_y(b_y),
    .eat(b_eat), .power_up(b_pwr), .score(b_score), .pellets_left(b_pl),
    .level_clear(b_lc), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    int          pulses;
    int          first;
    int          pw;
    int unsigned score;
    int unsigned pleft;
    int          lc;
  } vec_t;

  vec_t vecs [7];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (a_busy && cnt < 100) begin
      cnt++;
      step();
    end
    chk(name, cnt, 32);
  endtask

  task automatic watch(input int n, output int pulses, output int first, output int pw);
    pulses = 0;
    first  = 0;
    pw     = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (a_eat) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (a_pwr) pw++;
    end
  endtask

  initial begin
    int p, f, pw;
    rst_n = 1'b0; a_restart = 1'b0; b_restart = 1'b0;
    a_x = '0; a_y = '0; b_x = '0; b_y = '0;

    vecs[0] = '{5'd1, 5'd0, 1, 2, 0,      10,          2, 0};
    vecs[1] = '{5'd0, 5'd0, 0, 0, 0,      10,          2, 0};
    vecs[2] = '{5'd1, 5'd0, 0, 0, 0,      10,          2, 0};
    vecs[3] = '{5'd2, 5'd0, 1, 2, PWR_EN, 10 + P2,     1, 0};
    vecs[4] = '{5'd3, 5'd5, 1, 2, 0,      20 + P2,     0, 1};
    vecs[5] = '{5'd4, 5'd4, 0, 0, 0,      20 + P2,     0, 1};
    vecs[6] = '{5'd0, 5'd0, 0, 0, 0,      20 + P2,     0, 1};

    // Reset state
    repeat (2) step();
    chk("rst_busy", a_busy, 1);
    chk("rst_eat", a_eat, 0);
    chk("rst_score", a_score, 0);
    chk("rst_pleft", a_pl, 0);
    chk("rst_lclear", a_lc, 0);
    rst_n = 1'b1;

    wait_init("init_len");
    chk("init_pleft", a_pl, 3);
    chk("init_score", a_score, 0);
    chk("init_lclear", a_lc, 0);
    repeat (3) step();

    for (int i = 0; i < 7; i++) begin
      a_x = vecs[i].x;
      a_y = vecs[i].y;
      watch(4, p, f, pw);
      chk($sformatf("v%0d_pulses", i), p, vecs[i].pulses);
      chk($sformatf("v%0d_first", i), f, vecs[i].first);
      chk($sformatf("v%0d_power", i), pw, vecs[i].pw);
      chk($sformatf("v%0d_score", i), a_score, vecs[i].score);
      chk($sformatf("v%0d_pleft", i), a_pl, vecs[i].pleft);
      chk($sformatf("v%0d_lclear", i), a_lc, vecs[i].lc);
    end

    // Restart from DONE; start tile (1,0) is eaten right after INIT
    a_x = 5'd1; a_y = 5'd0; a_restart = 1'b1;
    step();
    a_restart = 1'b0;
    chk("rs_lclear", a_lc, 0);
    chk("rs_busy", a_busy, 1);
    chk("rs_pleft0", a_pl, 0);
    chk("rs_score_held", a_score, 20 + P2);
    wait_init("rs_init_len");
    chk("rs_pleft", a_pl, 3);
    watch(4, p, f, pw);
    chk("rs_start_pulses", p, 1);
    chk("rs_start_first", f, 2);
    chk("rs_score", a_score, 30 + P2);
    chk("rs_pleft2", a_pl, 2);

    // Restart in the same cycle as a CHECK hit discards the update
    a_x = 5'd2; a_y = 5'd0;
    step();
    a_restart = 1'b1;
    step();
    a_restart = 1'b0;
    chk("rc_eat", a_eat, 0);
    chk("rc_score", a_score, 30 + P2);
    chk("rc_busy", a_busy, 1);
    wait_init("rc_init_len");
    chk("rc_pleft", a_pl, 3);
    watch(4, p, f, pw);
    chk("rc_start_pulses", p, 1);
    chk("rc_power", pw, PWR_EN);
    chk("rc_score2", a_score, 30 + 2 * P2);
    chk("rc_pleft2", a_pl, 2);

    // Saturation on the 6-bit instance: start tile (0,0) already eaten
    chk("b_start_score", b_score, 10);
    chk("b_start_pleft", b_pl, 7);
    for (int x = 1; x <= 6; x++) begin
      b_x = 5'(x);
      repeat (4) step();
      chk($sformatf("b_score_x%0d", x), b_score, (10 * (x + 1) > 63) ? 63 : 10 * (x + 1));
      chk($sformatf("b_pleft_x%0d", x), b_pl, 7 - x);
    end

    // Asynchronous reset asserted mid-CHECK
    a_x = 5'd3; a_y = 5'd5;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_eat", a_eat, 0);
    chk("mr_score", a_score, 0);
    chk("mr_busy", a_busy, 1);
    chk("mr_pleft", a_pl, 0);
    step();
    rst_n = 1'b1;
    wait_init("mr_init_len");
    chk("mr_init_pleft", a_pl, 3);
    watch(4, p, f, pw);
    chk("mr_pulses", p, 1);
    chk("mr_score2", a_score, 10);
    chk("mr_pleft2", a_pl, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
